// File: rtl/sdp_y_core_triosy_multi_wait_ctrl_if.sv
// ---------------------------------------------------------------------------
// sdp_y_core_triosy_multi_wait_ctrl_if
// Handshake/status bundle for the multi-channel triosy wait controller.
//   Parameters: NCH   - number of triosy channels
//               CNT_W - width of each completion counter
//   Core-side controls : core_wen, core_wten, cnt_clr (shared by all channels)
//   Per-channel inputs : oswt, iswt0
//   Per-channel outputs: biwt, bdwt (combinational), triosy_lz, pend (registered)
//   Counters           : done_cnt, channel i at [i*CNT_W +: CNT_W]
//   Optional (TRIOSY_OVF_EN): ovf, sticky merged-request flags
// Modports: master drives the controls/requests, slave is the controller.
// ---------------------------------------------------------------------------
interface sdp_y_core_triosy_multi_wait_ctrl_if #(
   parameter int unsigned NCH   = 4,
   parameter int unsigned CNT_W = 8
);
   logic                   core_wen;
   logic                   core_wten;
   logic [NCH-1:0]         oswt;
   logic [NCH-1:0]         iswt0;
   logic                   cnt_clr;
   logic [NCH-1:0]         biwt;
   logic [NCH-1:0]         bdwt;
   logic [NCH-1:0]         triosy_lz;
   logic [NCH-1:0]         pend;
   logic [NCH*CNT_W-1:0]   done_cnt;
`ifdef TRIOSY_OVF_EN
   logic [NCH-1:0]         ovf;
`endif

   modport master (
      output core_wen, core_wten, oswt, iswt0, cnt_clr,
      input  biwt, bdwt, triosy_lz, pend, done_cnt
`ifdef TRIOSY_OVF_EN
      , input ovf
`endif
   );

   modport slave (
      input  core_wen, core_wten, oswt, iswt0, cnt_clr,
      output biwt, bdwt, triosy_lz, pend, done_cnt
`ifdef TRIOSY_OVF_EN
      , output ovf
`endif
   );
endinterface

// File: rtl/sdp_y_core_triosy_multi_wait_ctrl.sv
// ---------------------------------------------------------------------------
// sdp_y_core_triosy_multi_wait_ctrl
// Multi-channel triosy wait controller for the SDP Y core datapath.
// Per channel it generates the input-side (biwt) and output-side (bdwt)
// handshake enables, holds an input sync request that arrives during a
// stall and replays it on the first unstalled cycle, emits a registered
// one-cycle transaction-done pulse (triosy_lz) and keeps a saturating
// completion counter (done_cnt).
//
// Ports:
//   clk  - core clock, all state on the rising edge
//   rst  - asynchronous reset, active-high
//   bus  - slave side of sdp_y_core_triosy_multi_wait_ctrl_if
//            in : core_wen, core_wten, oswt[NCH], iswt0[NCH], cnt_clr
//            out: biwt[NCH], bdwt[NCH], triosy_lz[NCH], pend[NCH],
//                 done_cnt[NCH*CNT_W] (ovf[NCH] with TRIOSY_OVF_EN)
//
// Configuration macro: TRIOSY_OVF_EN adds the sticky ovf flags that record
// a request merged into an already held one. Undefined: merging is silent.
// ---------------------------------------------------------------------------
module sdp_y_core_triosy_multi_wait_ctrl #(
   parameter int unsigned NCH   = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic                                  clk,
   input  logic                                  rst,
   sdp_y_core_triosy_multi_wait_ctrl_if.slave    bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [NCH-1:0]              stall_v;
   logic [NCH-1:0]              req;
   logic [NCH-1:0]              biwt_c;
   logic [NCH-1:0]              pend_q;
   logic [NCH-1:0]              lz_q;
   logic [NCH-1:0][CNT_W-1:0]   cnt_q;

   // ------------------------------------------------------------------
   // Combinational handshake enables
   // ------------------------------------------------------------------
   assign stall_v = {NCH{bus.core_wten}};

   // A held request and a fresh one on the same channel collapse into a
   // single request; this is what makes merged requests fire only once.
   assign req    = bus.iswt0 | pend_q;
   assign biwt_c = req & ~stall_v;

   assign bus.biwt = biwt_c;
   assign bus.bdwt = bus.oswt & {NCH{bus.core_wen}};

   // ------------------------------------------------------------------
   // Held-request flag and done pulse
   // ------------------------------------------------------------------
   // The set/hold/clear rules reduce to "a request exists and the core is
   // stalled": set and hold both need core_wten=1, and any unstalled cycle
   // with a request is a biwt cycle, which clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q <= '0;
         lz_q   <= '0;
      end else begin
         pend_q <= req & stall_v;
         lz_q   <= biwt_c;
      end
   end

   assign bus.pend      = pend_q;
   assign bus.triosy_lz = lz_q;

   // ------------------------------------------------------------------
   // Saturating completion counters; clear wins over increment
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         for (int unsigned i = 0; i < NCH; i++) begin
            if (bus.cnt_clr) begin
               cnt_q[i] <= '0;
            end else if (biwt_c[i] && (cnt_q[i] != CNT_MAX)) begin
               cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   // Packed array element i occupies bits [i*CNT_W +: CNT_W].
   assign bus.done_cnt = cnt_q;

   // ------------------------------------------------------------------
   // Optional sticky overflow (merged request) flags
   // ------------------------------------------------------------------
`ifdef TRIOSY_OVF_EN
   logic [NCH-1:0] ovf_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= '0;
      end else if (bus.cnt_clr) begin
         ovf_q <= '0;
      end else begin
         ovf_q <= ovf_q | (bus.iswt0 & pend_q & stall_v);
      end
   end

   assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_sdp_y_core_triosy_multi_wait_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sdp_y_core_triosy_multi_wait_ctrl
// Scoreboard bench: the driver applies one input vector per cycle, asks a
// behavioural channel model what the outputs must be during that cycle and
// pushes the answer into a queue; the monitor pops and compares on the
// falling edge. Counters use CNT_W=4 so saturation is reachable quickly.
// ---------------------------------------------------------------------------
module tb_sdp_y_core_triosy_multi_wait_ctrl;

   localparam int unsigned NCH   = 4;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned CMAX  = (1 << CNT_W) - 1;

   logic clk;
   logic rst;

   sdp_y_core_triosy_multi_wait_ctrl_if #(.NCH(NCH), .CNT_W(CNT_W)) bus ();

   sdp_y_core_triosy_multi_wait_ctrl #(.NCH(NCH), .CNT_W(CNT_W)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [NCH-1:0]       biwt;
      logic [NCH-1:0]       bdwt;
      logic [NCH-1:0]       pend;
      logic [NCH-1:0]       lz;
      logic [NCH*CNT_W-1:0] cnt;
      logic [NCH-1:0]       ovf;
   } exp_t;

   exp_t sb[$];

   int unsigned checks = 0;
   int unsigned errors = 0;

   // Behavioural model: per channel, "is a request waiting", the done
   // pulse owed for this cycle, completions so far and the lost-request flag.
   bit          m_held[NCH];
   bit          m_lz[NCH];
   int unsigned m_cnt[NCH];
   bit          m_ovf[NCH];

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_held[i] = 0;
         m_lz[i]   = 0;
         m_cnt[i]  = 0;
         m_ovf[i]  = 0;
      end
   endtask

   function automatic exp_t model_outputs(bit wen, bit wten, logic [NCH-1:0] os,
                                          logic [NCH-1:0] is);
      exp_t e;
      for (int i = 0; i < NCH; i++) begin
         e.biwt[i] = (is[i] || m_held[i]) && !wten;
         e.bdwt[i] = os[i] && wen;
         e.pend[i] = m_held[i];
         e.lz[i]   = m_lz[i];
         e.ovf[i]  = m_ovf[i];
         for (int b = 0; b < CNT_W; b++) e.cnt[i*CNT_W + b] = m_cnt[i][b];
      end
      return e;
   endfunction

   task automatic model_advance(bit wten, bit clr, logic [NCH-1:0] is);
      for (int i = 0; i < NCH; i++) begin
         bool_fire: begin
            bit fire;
            fire = (is[i] || m_held[i]) && !wten;
            if (clr)                           m_ovf[i] = 0;
            else if (is[i] && m_held[i] && wten) m_ovf[i] = 1;
            m_lz[i] = fire;
            if (clr)                           m_cnt[i] = 0;
            else if (fire && m_cnt[i] < CMAX)  m_cnt[i] = m_cnt[i] + 1;
            m_held[i] = (is[i] || m_held[i]) && wten;
         end
      end
   endtask

   // One clock cycle of stimulus: drive, predict, push, advance the model.
   task automatic step(bit r, bit wen, bit wten, bit clr,
                       logic [NCH-1:0] os, logic [NCH-1:0] is);
      @(posedge clk);
      #1;
      rst           = r;
      bus.core_wen  = wen;
      bus.core_wten = wten;
      bus.cnt_clr   = clr;
      bus.oswt      = os;
      bus.iswt0     = is;
      if (r) model_reset();
      sb.push_back(model_outputs(wen, wten, os, is));
      if (r) model_reset();
      else   model_advance(wten, clr, is);
   endtask

   // Raise rst in the middle of a stalled cycle; state must clear at once.
   task automatic reset_mid_cycle();
      @(posedge clk);
      #3;
      rst = 1'b1;
      model_reset();
      sb.push_back(model_outputs(bus.core_wen, bus.core_wten, bus.oswt, bus.iswt0));
   endtask

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor
   initial begin
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("biwt",      64'(bus.biwt),      64'(e.biwt));
            check("bdwt",      64'(bus.bdwt),      64'(e.bdwt));
            check("pend",      64'(bus.pend),      64'(e.pend));
            check("triosy_lz", 64'(bus.triosy_lz), 64'(e.lz));
            check("done_cnt",  64'(bus.done_cnt),  64'(e.cnt));
`ifdef TRIOSY_OVF_EN
            check("ovf",       64'(bus.ovf),       64'(e.ovf));
`endif
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, queue depth %0d", sb.size());
      $fatal(1, "bench time limit");
   end

   // Driver
   initial begin
      rst           = 1'b1;
      bus.core_wen  = 1'b0;
      bus.core_wten = 1'b0;
      bus.cnt_clr   = 1'b0;
      bus.oswt      = '0;
      bus.iswt0     = '0;
      model_reset();

      step(1, 0, 0, 0, 4'b0000, 4'b0000);
      step(1, 0, 0, 0, 4'b0000, 4'b0000);
      step(0, 0, 0, 0, 4'b0000, 4'b0000);

      // Single unstalled request on channel 0
      step(0, 0, 0, 0, 4'b0000, 4'b0001);
      step(0, 0, 0, 0, 4'b0000, 4'b0000);
      step(0, 0, 0, 0, 4'b0000, 4'b0000);

      // Request on channel 2 held through a 4-cycle stall
      step(0, 0, 1, 0, 4'b0000, 4'b0100);
      repeat (3) step(0, 0, 1, 0, 4'b0000, 4'b0000);
      step(0, 0, 0, 0, 4'b0000, 4'b0000);
      step(0, 0, 0, 0, 4'b0000, 4'b0000);

      // Two requests on channel 1 during one stall merge into one
      step(0, 0, 1, 0, 4'b0000, 4'b0010);
      step(0, 0, 1, 0, 4'b0000, 4'b0000);
      step(0, 0, 1, 0, 4'b0000, 4'b0010);
      step(0, 0, 1, 0, 4'b0000, 4'b0000);
      step(0, 0, 0, 0, 4'b0000, 4'b0000);
      step(0, 0, 0, 0, 4'b0000, 4'b0000);

      // Fresh request coinciding with a held one in an unstalled cycle
      step(0, 0, 1, 0, 4'b0000, 4'b1000);
      step(0, 0, 0, 0, 4'b0000, 4'b1000);
      step(0, 0, 0, 0, 4'b0000, 4'b0000);

      // Saturation of channel 3, then clear against a same-cycle increment
      repeat (20) step(0, 0, 0, 0, 4'b0000, 4'b1000);
      step(0, 0, 0, 1, 4'b0000, 4'b1000);
      step(0, 0, 0, 0, 4'b0000, 4'b0000);

      // bdwt gating by core_wen only
      step(0, 0, 0, 0, 4'b1010, 4'b0000);
      step(0, 1, 0, 0, 4'b1010, 4'b0000);
      step(0, 1, 1, 0, 4'b1010, 4'b0000);
      step(0, 0, 1, 0, 4'b1010, 4'b0000);

      // Asynchronous reset while channel 0 holds a request
      step(0, 0, 1, 0, 4'b0000, 4'b0001);
      step(0, 0, 1, 0, 4'b0000, 4'b0000);
      reset_mid_cycle();
      step(1, 0, 1, 0, 4'b0000, 4'b0000);
      step(0, 0, 0, 0, 4'b0000, 4'b0000);
      step(0, 0, 0, 0, 4'b0000, 4'b0000);

      // Randomised traffic
      for (int n = 0; n < 400; n++) begin
         step(0,
              1'($urandom_range(0, 1)),
              ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 40) == 0),
              4'($urandom),
              4'($urandom) & 4'($urandom));
      end
      step(0, 0, 0, 0, 4'b0000, 4'b0000);

      repeat (3) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sdp_y_core_triosy_multi_wait_ctrl.md
Name: sdp_y_core_triosy_multi_wait_ctrl

Overview:
Parametrised, multi-channel successor to the single-channel triosy wait controller in the SDP Y core datapath. For each of NCH config/status channels it generates the input-side (biwt) and output-side (bdwt) handshake enables. It also holds any sync request that arrives while the core is stalled and replays it when the stall clears. It adds a registered per-channel transaction-done (triosy_lz) pulse and a saturating completion counter for debug and perf visibility.

Parameters:
NCH, 4, number of independent triosy channels
CNT_W, 8, width of each per-channel completion counter

Ports:
clk  input  1  core clock, all state rising-edge
rst  input  1  asynchronous reset, active-high
core_wen  input  1  core write enable (non-stalled datapath cycle)
core_wten  input  1  core wait/stall indicator; 1 = stalled
oswt  input  NCH  per-channel output-side sync request
iswt0  input  NCH  per-channel input-side sync request
cnt_clr  input  1  synchronous clear of all completion counters
biwt  output  NCH  per-channel input handshake enable (combinational)
bdwt  output  NCH  per-channel output handshake enable (combinational)
triosy_lz  output  NCH  registered one-cycle transaction-done pulse
pend  output  NCH  registered held-request flag
done_cnt  output  NCH*CNT_W  packed counters; channel i at [i*CNT_W +: CNT_W]

Behaviour:
- Clock/reset fixed: one clock clk; rst asynchronous, active-high. All registers clear immediately on rst assertion, independent of clk.
- Reset values: pend=0, triosy_lz=0, done_cnt=0 (all channels). biwt and bdwt are combinational and evaluate to 0 while their inputs are 0.
- Channels are fully independent. Only core_wen, core_wten and cnt_clr are shared.
- bdwt[i] = oswt[i] & core_wen. Zero latency, no state.
- req[i] = iswt0[i] | pend[i].
- biwt[i] = req[i] & ~core_wten. Zero latency.
- pend[i] next-state rules:
  - set when iswt0[i] & core_wten & ~pend[i];
  - hold when pend[i] & core_wten;
  - clear when biwt[i];
  - otherwise 0.
- A request arriving during a stall therefore fires biwt on the first cycle with core_wten=0.
- iswt0[i] asserted while pend[i] is already 1 and still stalled merges into the held request: one biwt, one count.
- iswt0[i] and pend[i] both 1 in a non-stall cycle produce a single biwt and clear pend.
- triosy_lz[i] <= biwt[i]. Latency 1 cycle; high for exactly one cycle per biwt cycle. Back-to-back biwt gives back-to-back pulses.
- done_cnt[i]:
  - increments by 1 on each biwt[i] cycle;
  - saturates at 2^CNT_W-1 (no wrap);
  - cnt_clr=1 forces all counters to 0 that cycle, taking priority over a same-cycle increment.
- Reset during a held request discards it: pend=0, no replayed biwt after reset release.
- core_wen has no effect on biwt or pend. core_wten has no effect on bdwt.

Optional Feature:
Macro TRIOSY_OVF_EN.
- Defined: adds output ovf (NCH bits, registered, reset 0). ovf[i] is set sticky when iswt0[i] arrives while pend[i]=1 and core_wten=1, i.e. a merged (lost) request. ovf is cleared only by cnt_clr or rst.
- Undefined: the ovf port and its logic are absent; merging is silent.

Test Plan:
- Reset, then core_wten=0, iswt0=4'b0001 for 1 cycle -> biwt=4'b0001 same cycle; triosy_lz[0]=1 next cycle only; done_cnt[0]=1.
- core_wten=1, iswt0[2] pulsed 1 cycle, stall held 3 more cycles, then core_wten=0 -> pend[2]=1 for 4 cycles; biwt[2]=1 on the first unstalled cycle; pend[2]=0 after; done_cnt[2]=1.
- Stalled, iswt0[1] pulsed twice with stall held -> single biwt[1] after release; done_cnt[1]=1; ovf[1]=1 with TRIOSY_OVF_EN.
- CNT_W=4: 20 consecutive biwt[3] cycles -> done_cnt[3] saturates at 15. Then cnt_clr=1 with biwt[3]=1 that cycle -> 0 next cycle.
- oswt=4'b1010: core_wen=0 -> bdwt=0; core_wen=1 -> bdwt=4'b1010, independent of core_wten.
- Stalled with pend[0]=1, assert rst asynchronously mid-cycle -> pend, triosy_lz, done_cnt all 0 immediately; no biwt after release with iswt0=0.
